// File: rtl/boids_pkg.sv
// rtl/boids_pkg.sv - shared constants, boid position record and writer FSM states
package boids_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int ADDR_WIDTH = 20;
    localparam int DATA_WIDTH = 9;

    localparam logic [DATA_WIDTH-1:0] BOID_COLOR = 9'd42;
    localparam logic [DATA_WIDTH-1:0] BG_COLOR   = 9'd31;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       en;
    } boid_pos_t;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        DONE
    } fb_state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// rtl/sprite_scan_counter.sv - nested slot/dy/dx sprite pixel counter with last-pixel flag
module sprite_scan_counter #(
    parameter int N_SLOTS = 16,
    parameter int SIZE    = 2,
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    localparam int SZ_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [SLOT_W-1:0] o_slot,
    output logic [SZ_W-1:0]   o_dy,
    output logic [SZ_W-1:0]   o_dx,
    output logic              o_last
);

    localparam logic [SZ_W-1:0]   D_MAX    = SZ_W'(SIZE - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(N_SLOTS - 1);

    logic [SLOT_W-1:0] r_slot;
    logic [SZ_W-1:0]   r_dy;
    logic [SZ_W-1:0]   r_dx;

    assign o_slot = r_slot;
    assign o_dy   = r_dy;
    assign o_dx   = r_dx;
    assign o_last = (r_slot == SLOT_MAX) && (r_dy == D_MAX) && (r_dx == D_MAX);

    // Wraps back to zero after the last pixel so the next phase starts clean.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot <= '0;
            r_dy   <= '0;
            r_dx   <= '0;
        end else if (i_clear) begin
            r_slot <= '0;
            r_dy   <= '0;
            r_dx   <= '0;
        end else if (i_advance) begin
            if (r_dx == D_MAX) begin
                r_dx <= '0;
                if (r_dy == D_MAX) begin
                    r_dy   <= '0;
                    r_slot <= (r_slot == SLOT_MAX) ? '0 : r_slot + 1'b1;
                end else begin
                    r_dy <= r_dy + 1'b1;
                end
            end else begin
                r_dx <= r_dx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boid_fb_writer.sv
// rtl/boid_fb_writer.sv - per-frame erase/redraw of boid sprites into the framebuffer write port
module boid_fb_writer
    import boids_pkg::*;
#(
    parameter int N_BOIDS   = 16,
    parameter int BOID_SIZE = 2,
    localparam int IDX_W    = (N_BOIDS > 1) ? $clog2(N_BOIDS) : 1,
    localparam int SZ_W     = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_frame_start,
    input  logic                  i_pos_wen,
    input  logic [IDX_W-1:0]      i_pos_idx,
    input  logic [9:0]            i_pos_x,
    input  logic [8:0]            i_pos_y,
    input  logic                  i_pos_en,
    output logic [ADDR_WIDTH-1:0] o_fb_addr,
    output logic [DATA_WIDTH-1:0] o_fb_data,
    output logic                  o_fb_wen,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);

    boid_pos_t r_shadow [N_BOIDS];
    boid_pos_t r_cur    [N_BOIDS];
    boid_pos_t r_drawn  [N_BOIDS];
    fb_state_t r_state;

    logic [IDX_W-1:0]      w_slot;
    logic [SZ_W-1:0]       w_dy;
    logic [SZ_W-1:0]       w_dx;
    logic                  w_last;
    logic                  w_start;
    logic                  w_scanning;
    boid_pos_t             w_ent;
    logic [10:0]           w_sx;
    logic [9:0]            w_sy;
    logic                  w_in_bounds;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_start    = (r_state == IDLE) && i_frame_start;
    assign w_scanning = (r_state == ERASE) || (r_state == DRAW);

    sprite_scan_counter #(
        .N_SLOTS (N_BOIDS),
        .SIZE    (BOID_SIZE)
    ) u_scan (
        .i_clk     (i_clk),
        .i_rst     (i_reset),
        .i_clear   (w_start),
        .i_advance (w_scanning),
        .o_slot    (w_slot),
        .o_dy      (w_dy),
        .o_dx      (w_dx),
        .o_last    (w_last)
    );

    // Widened sums so a sprite near 1023/511 clips instead of wrapping to the left/top.
    always_comb begin
        w_ent       = (r_state == ERASE) ? r_drawn[w_slot] : r_cur[w_slot];
        w_sx        = {1'b0, w_ent.x} + 11'(w_dx);
        w_sy        = {1'b0, w_ent.y} + 10'(w_dy);
        w_in_bounds = (w_sx < 11'(SCREEN_W)) && (w_sy < 10'(SCREEN_H));
        w_addr      = ADDR_WIDTH'(w_sx) + ADDR_WIDTH'(w_sy) * ADDR_WIDTH'(SCREEN_W);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_BOIDS; i++) begin
                r_shadow[i] <= '0;
                r_cur[i]    <= '0;
                r_drawn[i]  <= '0;
            end
            r_state   <= IDLE;
            o_fb_addr <= '0;
            o_fb_data <= '0;
            o_fb_wen  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (i_pos_wen) begin
                r_shadow[i_pos_idx] <= '{x: i_pos_x, y: i_pos_y, en: i_pos_en};
            end
            if (i_frame_start && (r_state != IDLE)) begin
                o_overrun <= 1'b1;
            end
            o_fb_wen <= 1'b0;
            o_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_frame_start) begin
                        r_cur   <= r_shadow;
                        r_state <= ERASE;
                    end
                end
                ERASE, DRAW: begin
                    o_busy    <= 1'b1;
                    o_fb_wen  <= w_ent.en && w_in_bounds;
                    o_fb_addr <= w_addr;
                    o_fb_data <= (r_state == ERASE) ? BG_COLOR : BOID_COLOR;
                    if (w_last) begin
                        r_state <= (r_state == ERASE) ? DRAW : DONE;
                    end
                end
                DONE: begin
                    r_drawn <= r_cur;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boid_fb_writer.sv
// tb/tb_boid_fb_writer.sv - scoreboard bench for boid_fb_writer
module tb_boid_fb_writer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_frame_start = 1'b0;
    logic        i_pos_wen = 1'b0;
    logic [3:0]  i_pos_idx = '0;
    logic [9:0]  i_pos_x = '0;
    logic [8:0]  i_pos_y = '0;
    logic        i_pos_en = 1'b0;
    logic [19:0] o_fb_addr;
    logic [8:0]  o_fb_data;
    logic        o_fb_wen;
    logic        o_busy;
    logic        o_done;
    logic        o_overrun;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int exp_addr[$];
    int exp_data[$];
    int done_q[$];

    boid_fb_writer dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_frame_start (i_frame_start),
        .i_pos_wen     (i_pos_wen),
        .i_pos_idx     (i_pos_idx),
        .i_pos_x       (i_pos_x),
        .i_pos_y       (i_pos_y),
        .i_pos_en      (i_pos_en),
        .o_fb_addr     (o_fb_addr),
        .o_fb_data     (o_fb_data),
        .o_fb_wen      (o_fb_wen),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overrun     (o_overrun)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic px(input int a, input int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // Sprite at top-left address a: scan order dy outer, dx inner.
    task automatic px4(input int a, input int d);
        px(a, d);
        px(a + 1, d);
        px(a + 640, d);
        px(a + 641, d);
    endtask

    task automatic load(input int idx, input int x, input int y, input bit en);
        @(negedge i_clk);
        i_pos_wen = 1'b1;
        i_pos_idx = 4'(idx);
        i_pos_x   = 10'(x);
        i_pos_y   = 9'(y);
        i_pos_en  = en;
        @(negedge i_clk);
        i_pos_wen = 1'b0;
    endtask

    // Done is visible after edge P+1 counted from the sampling edge.
    task automatic start_pass(input bit push_done, input bit with_load, input int x, input int y);
        @(negedge i_clk);
        i_frame_start = 1'b1;
        if (with_load) begin
            i_pos_wen = 1'b1;
            i_pos_idx = 4'd0;
            i_pos_x   = 10'(x);
            i_pos_y   = 9'(y);
            i_pos_en  = 1'b1;
        end
        if (push_done) done_q.push_back(cyc + 130);
        @(negedge i_clk);
        i_frame_start = 1'b0;
        i_pos_wen     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
        chk(name, int'(seen), 1);
        repeat (4) @(negedge i_clk);
    endtask

    always @(negedge i_clk) begin
        if (i_reset) begin
            busy_cnt = 0;
        end else begin
            if (o_fb_wen) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write_addr", int'(o_fb_addr), -1);
                end else begin
                    chk("write_addr", int'(o_fb_addr), exp_addr.pop_front());
                    chk("write_data", int'(o_fb_data), exp_data.pop_front());
                end
            end
            if (o_busy) busy_cnt++;
            if (o_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("busy_cycles", busy_cnt, 128);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge i_clk);
        chk("reset_fb_addr", int'(o_fb_addr), 0);
        chk("reset_fb_data", int'(o_fb_data), 0);
        chk("reset_fb_wen", int'(o_fb_wen), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_overrun", int'(o_overrun), 0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        load(0, 100, 50, 1'b1);
        px4(32100, 42);
        start_pass(1'b1, 1'b0, 0, 0);
        wait_done("t1_done");

        load(0, 101, 50, 1'b1);
        px4(32100, 31);
        px4(32101, 42);
        start_pass(1'b1, 1'b0, 0, 0);
        wait_done("t2_done");

        load(3, 639, 479, 1'b1);
        px4(32101, 31);
        px4(32101, 42);
        px(307199, 42);
        start_pass(1'b1, 1'b0, 0, 0);
        wait_done("t3_done");

        px4(32101, 31);
        px(307199, 31);
        px4(32101, 42);
        px(307199, 42);
        start_pass(1'b1, 1'b0, 0, 0);
        repeat (8) @(negedge i_clk);
        i_frame_start = 1'b1;
        @(negedge i_clk);
        i_frame_start = 1'b0;
        wait_done("t4_done");
        chk("t4_overrun", int'(o_overrun), 1);

        px4(32101, 31);
        px(307199, 31);
        px4(32101, 42);
        px(307199, 42);
        start_pass(1'b1, 1'b1, 200, 10);
        wait_done("t5a_done");
        px4(32101, 31);
        px(307199, 31);
        px4(6600, 42);
        px(307199, 42);
        start_pass(1'b1, 1'b0, 0, 0);
        wait_done("t5b_done");
        chk("t5_overrun_sticky", int'(o_overrun), 1);

        px4(6600, 31);
        px(307199, 31);
        start_pass(1'b0, 1'b0, 0, 0);
        repeat (39) @(negedge i_clk);
        #1 i_reset = 1'b1;
        #1;
        chk("t6_wen_async", int'(o_fb_wen), 0);
        chk("t6_busy_async", int'(o_busy), 0);
        chk("t6_done_async", int'(o_done), 0);
        chk("t6_overrun_cleared", int'(o_overrun), 0);
        chk("t6_erase_writes_left", exp_addr.size(), 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        load(5, 0, 0, 1'b1);
        px4(0, 42);
        start_pass(1'b1, 1'b0, 0, 0);
        wait_done("t6_done");

        repeat (10) @(negedge i_clk);
        chk("final_writes_left", exp_addr.size(), 0);
        chk("final_dones_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
